// File: rtl/data_mem_resp.sv
// Data-memory responder for the ME stage: one outstanding load/store at a
// time, fixed programmable latency, byte/half/word access on a word RAM,
// with error responses for misaligned or illegal-size requests.
module data_mem_resp #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        busy_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    we_q;
    logic [ADDR_WIDTH+1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [1:0]              size_q;
    logic                    uns_q;

    logic [31:0]             mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   idx;
    logic [1:0]              lane;
    logic                    acc_err;
    logic                    commit;
    logic [3:0]              be;
    logic [31:0]             wword;
    logic [31:0]             rword;
    logic [31:0]             rshift;
    logic [15:0]             rhalf;
    logic [31:0]             ldata;

    // Address bits above the RAM index wrap away by design.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, req_addr_i[31:ADDR_WIDTH+2]};

    // Handshake-facing status derived from the registered state.
    always_comb begin
        req_ready_o = (state == IDLE);
        busy_o      = (state != IDLE);
    end

    // Decode the latched request: alignment check, store lanes, load extraction.
    always_comb begin
        idx     = addr_q[ADDR_WIDTH+1:2];
        lane    = addr_q[1:0];
        commit  = (state == WAIT) && (cnt == '0);
        case (size_q)
            2'b00:   acc_err = 1'b0;
            2'b01:   acc_err = lane[0];
            2'b10:   acc_err = (lane != 2'b00);
            default: acc_err = 1'b1;
        endcase

        be    = '0;
        wword = wdata_q;
        case (size_q)
            2'b00: begin
                be    = 4'b0001 << lane;
                wword = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << lane;
                wword = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                be    = 4'b1111;
                wword = wdata_q;
            end
            default: begin
                be    = '0;
                wword = wdata_q;
            end
        endcase
        if (!we_q || acc_err) begin
            be = '0;
        end

        rword  = mem[idx];
        rshift = rword >> {lane, 3'b000};
        rhalf  = lane[1] ? rword[31:16] : rword[15:0];
        case (size_q)
            2'b00:   ldata = uns_q ? {24'b0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
            2'b01:   ldata = uns_q ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
            2'b10:   ldata = rword;
            default: ldata = '0;
        endcase
    end

    // RAM write port: only at commit, never while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

    // Request/latency/response sequencer with registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        addr_q  <= req_addr_i[ADDR_WIDTH+1:0];
                        wdata_q <= req_wdata_i;
                        size_q  <= req_size_i;
                        uns_q   <= req_unsigned_i;
                        cnt     <= 4'(LATENCY - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state        <= RESP;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= acc_err;
                        resp_rdata_o <= (we_q || acc_err) ? '0 : ldata;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state        <= IDLE;
                        resp_valid_o <= 1'b0;
                        resp_rdata_o <= '0;
                        resp_err_o   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: a table of load/store vectors with
// hand-computed results, plus sequences for stall, reset-in-WAIT and wrap.
module tb_data_mem_resp;

    localparam int AW  = 10;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    data_mem_resp #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_rdata_o   (resp_rdata_o),
        .resp_err_o     (resp_err_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input string nm, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.name = nm; v.we = we; v.addr = addr; v.wdata = wdata; v.size = size;
        v.uns = uns; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; returns after the response handshake.
    task automatic run_req(input string nm, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                           output logic [31:0] rd, output logic er, output int lat);
        int n;
        chk({nm, ".ready"}, {31'b0, req_ready_o}, 32'd1);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        req_size_i     = size;
        req_unsigned_i = uns;
        @(negedge clk);
        req_valid_i = 1'b0;
        n = 0;
        while (!resp_valid_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        rd  = resp_rdata_o;
        er  = resp_err_o;
        if (!resp_valid_o) begin
            checks++;
            failures++;
            $display("FAIL %s.timeout actual=no_resp required=resp_valid", nm);
        end
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;

        rst_n = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
        req_wdata_i = '0; req_size_i = '0; req_unsigned_i = 1'b0; resp_ready_i = 1'b0;

        vecs[0]  = mk("st_w_10",    1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0);
        vecs[1]  = mk("ld_w_10",    1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
        vecs[2]  = mk("st_b_11",    1'b1, 32'h11, 32'hFFFFFF80, 2'b00, 1'b0, 32'h0,        1'b0);
        vecs[3]  = mk("lb_11",      1'b0, 32'h11, 32'h0,        2'b00, 1'b0, 32'hFFFFFF80, 1'b0);
        vecs[4]  = mk("lbu_11",     1'b0, 32'h11, 32'h0,        2'b00, 1'b1, 32'h00000080, 1'b0);
        vecs[5]  = mk("ld_w_10b",   1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 32'hDEAD80EF, 1'b0);
        vecs[6]  = mk("st_h_12",    1'b1, 32'h12, 32'h12348001, 2'b01, 1'b0, 32'h0,        1'b0);
        vecs[7]  = mk("lh_12",      1'b0, 32'h12, 32'h0,        2'b01, 1'b0, 32'hFFFF8001, 1'b0);
        vecs[8]  = mk("lhu_12",     1'b0, 32'h12, 32'h0,        2'b01, 1'b1, 32'h00008001, 1'b0);
        vecs[9]  = mk("lh_13_mis",  1'b0, 32'h13, 32'h0,        2'b01, 1'b0, 32'h0,        1'b1);
        vecs[10] = mk("st_w_04",    1'b1, 32'h04, 32'h12345678, 2'b10, 1'b0, 32'h0,        1'b0);
        vecs[11] = mk("st_w_06mis", 1'b1, 32'h06, 32'hAAAAAAAA, 2'b10, 1'b0, 32'h0,        1'b1);
        vecs[12] = mk("ld_w_04",    1'b0, 32'h04, 32'h0,        2'b10, 1'b0, 32'h12345678, 1'b0);
        vecs[13] = mk("ld_sz3",     1'b0, 32'h04, 32'h0,        2'b11, 1'b0, 32'h0,        1'b1);
        vecs[14] = mk("st_sz3",     1'b1, 32'h04, 32'hFFFFFFFF, 2'b11, 1'b0, 32'h0,        1'b1);
        vecs[15] = mk("ld_w_04b",   1'b0, 32'h04, 32'h0,        2'b10, 1'b0, 32'h12345678, 1'b0);
        vecs[16] = mk("lbu_13",     1'b0, 32'h13, 32'h0,        2'b00, 1'b1, 32'h00000080, 1'b0);
        vecs[17] = mk("lb_10",      1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 32'hFFFFFFEF, 1'b0);

        repeat (3) @(negedge clk);
        chk("rst.valid", {31'b0, resp_valid_o}, 32'd0);
        chk("rst.rdata", resp_rdata_o, 32'h0);
        chk("rst.err",   {31'b0, resp_err_o}, 32'd0);
        chk("rst.busy",  {31'b0, busy_o}, 32'd0);
        chk("rst.ready", {31'b0, req_ready_o}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            run_req(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size,
                    vecs[i].uns, rd, er, lat);
            chk({vecs[i].name, ".rdata"}, rd, vecs[i].exp_rdata);
            chk({vecs[i].name, ".err"}, {31'b0, er}, {31'b0, vecs[i].exp_err});
            chk({vecs[i].name, ".lat"}, lat, LAT);
        end

        // Stall: hold resp_ready low with a competing store request pending.
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h10; req_size_i = 2'b10;
        req_unsigned_i = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b0;
        n = 0;
        while (!resp_valid_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("stall.lat", n, LAT);
        chk("stall.rdata0", resp_rdata_o, 32'h800180EF);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h10; req_wdata_i = 32'h0;
        req_size_i = 2'b10;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall.valid", {31'b0, resp_valid_o}, 32'd1);
            chk("stall.rdata", resp_rdata_o, 32'h800180EF);
            chk("stall.ready", {31'b0, req_ready_o}, 32'd0);
            chk("stall.busy",  {31'b0, busy_o}, 32'd1);
        end
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        req_valid_i  = 1'b0;
        chk("stall.hs_valid", {31'b0, resp_valid_o}, 32'd0);
        chk("stall.hs_busy",  {31'b0, busy_o}, 32'd0);
        run_req("stall_reload", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
        chk("stall_reload.rdata", rd, 32'h800180EF);

        // Reset while a store is waiting: the store must never land.
        run_req("pre_st_20", 1'b1, 32'h20, 32'h11111111, 2'b10, 1'b0, rd, er, lat);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h20;
        req_wdata_i = 32'h22222222; req_size_i = 2'b10;
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("rwait.busy", {31'b0, busy_o}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rwait.valid", {31'b0, resp_valid_o}, 32'd0);
        chk("rwait.rdata", resp_rdata_o, 32'h0);
        chk("rwait.err",   {31'b0, resp_err_o}, 32'd0);
        chk("rwait.busy0", {31'b0, busy_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_req("rwait_ld", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, er, lat);
        chk("rwait_ld.rdata", rd, 32'h11111111);

        // Address wrap: 0x1000 aliases word 0 with ADDR_WIDTH=10.
        run_req("wrap_st", 1'b1, 32'h1000, 32'hCAFEF00D, 2'b10, 1'b0, rd, er, lat);
        run_req("wrap_ld", 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, rd, er, lat);
        chk("wrap_ld.rdata", rd, 32'hCAFEF00D);
        chk("wrap_ld.err", {31'b0, er}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- Data-memory responder serving the load/store requests issued by the ME (memory-access) stage of the RISC-V pipeline.
- Accepts one request at a time over a valid/ready handshake and performs byte/half/word access on an internal word-organised RAM.
- Returns sign- or zero-extended load data, or a store completion, after a fixed programmable latency.
- Flags misaligned or illegal-size accesses with an error response.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM holds 2^ADDR_WIDTH 32-bit words
LATENCY, 2, cycles from request acceptance to resp_valid_o; legal range 1..15

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
req_valid_i  input  1  ME stage presents a request
req_ready_o  output  1  responder can accept a request this cycle
req_we_i  input  1  1 = store, 0 = load
req_addr_i  input  32  byte address
req_wdata_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned_i  input  1  load zero-extends when 1 (LBU/LHU), sign-extends when 0
resp_valid_o  output  1  response available
resp_ready_i  input  1  ME stage consumes the response
resp_rdata_o  output  32  extended load data; 0 for stores and errors
resp_err_o  output  1  misaligned or illegal-size request
busy_o  output  1  high in any state other than IDLE; used as pipeline stall

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, latency counter=0.
  - RAM contents are not cleared.
  - Reset mid-operation abandons the request; a store not yet committed (state WAIT) is never written.
- States:
  - IDLE: req_ready_o=1.
    - On req_valid_i & req_ready_o, latch we/addr/wdata/size/unsigned.
    - Load counter with LATENCY-1 and go to WAIT.
  - WAIT: req_ready_o=0.
    - If counter==0, commit the access and go to RESP; otherwise decrement.
  - RESP: resp_valid_o=1.
    - Outputs are held stable until resp_ready_i=1, then return to IDLE.
    - No new request is accepted in the same cycle as the resp handshake.
- Latency: request accepted at edge N gives resp_valid_o high after edge N+LATENCY. Minimum throughput is one request per LATENCY+2 cycles.
- Addressing:
  - Word index = addr[ADDR_WIDTH+1:2]; upper address bits are ignored, so addresses wrap modulo RAM size.
  - Byte lane = addr[1:0].
- Alignment:
  - Half requires addr[0]=0; word requires addr[1:0]=00.
  - A violation, or size=11, gives resp_err_o=1 and resp_rdata_o=0, and the RAM is unmodified.
  - Error requests take the same latency as legal ones.
- Commit, at the WAIT→RESP edge:
  - Store: write only the addressed lanes (byte mask 0001<<lane, 0011<<lane, or 1111) with wdata replicated into position; resp_rdata_o=0.
  - Load: select the lane(s) from the read word. Byte extends bit 7, half extends bit 15; both zero-extend when unsigned. Word passes through.
- Loads always observe all previously committed stores (single outstanding request, so no hazards).
- busy_o = (state != IDLE).
- Inputs are ignored outside IDLE.

Test Plan:
- Store word 0xDEADBEEF @0x10, then load word @0x10 → resp_rdata_o=0xDEADBEEF, resp_err_o=0; resp_valid_o rises exactly LATENCY edges after acceptance.
- After the above, store byte 0x80 @0x11; load signed byte @0x11 → 0xFFFFFF80; load unsigned byte → 0x00000080; load word @0x10 → 0xDEAD80EF.
- Store half 0x8001 @0x12; signed half load → 0xFFFF8001; unsigned half → 0x00008001; half load @0x13 → err=1, rdata=0.
- Word store @0x06 (misaligned) → err=1; a subsequent word load @0x04 returns the prior contents unchanged; size=11 request → err=1.
- Hold resp_ready_i=0 for 5 cycles → resp_valid_o and data stay stable, req_ready_o=0, busy_o=1; a new req_valid_i in that window is not accepted.
- Issue a store, assert rst_n=0 while in WAIT → after reset all outputs are 0 and state is IDLE; a load of that address returns the old value. With ADDR_WIDTH=10, store @0x1000 then load @0x0000 returns the same data (wrap-around).
